// File: rtl/addsub_pkg.sv
// Purpose: shared types and constant helpers for the multi-cycle adder/subtractor.
//   state_e     : controller states (IDLE, BUSY, DONE)
//   calc_n      : number of chunks per operation (WIDTH/CHUNK)
//   calc_iw     : chunk index width, $clog2(N) with a minimum of 1
//   sat_max_pos : most positive two's complement value for a given width
//   sat_min_neg : most negative two's complement value for a given width
// The saturation helpers return MAX_W-bit values; callers cast them to WIDTH.
package addsub_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_n(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned calc_iw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max_pos(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min_neg(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Purpose: CHUNK-bit ripple adder built from full_adder cells.
//   a, b   : CHUNK-bit addends
//   cin    : carry into bit 0
//   sum    : CHUNK-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .sum (sum[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Purpose: single-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/addsub_multicycle.sv
// Purpose: multi-cycle adder/subtractor processing CHUNK bits per clock, LSB
// chunk first, through a single chunk_adder. Result in WIDTH/CHUNK cycles.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub[, sat])
//   out_valid / out_ready: result handshake (sum, cout, ovf, zero)
//   cout : carry out of MSB (no-borrow for subtract)
//   ovf  : signed overflow
//   zero : final (post-saturation) sum is zero
// Optional: define ADDSUB_SAT_EN to add the sat port and signed saturation.
module addsub_multicycle
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = calc_n(WIDTH, CHUNK);
  localparam int unsigned IW = calc_iw(N);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("addsub_multicycle: WIDTH must be a multiple of CHUNK");
  end

  state_e            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic [IW-1:0]     r_idx;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_out_valid;

  logic [CHUNK-1:0]  w_chunk_sum;
  logic              w_cout;
  logic              w_c_msb;
  logic              w_ovf;
  logic              w_last;
  logic [31:0]       w_shamt;
  logic [WIDTH-1:0]  w_sum_next;
  logic [WIDTH-1:0]  w_result;

  // Operands are shifted right each cycle so the active chunk is always at bit 0.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (r_a[CHUNK-1:0]),
    .b    (r_b[CHUNK-1:0]),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_cout),
    .c_msb(w_c_msb)
  );

  assign w_last  = (r_idx == IW'(N - 1));
  assign w_ovf   = w_c_msb ^ w_cout;
  assign w_shamt = 32'(r_idx) * 32'(CHUNK);

  // Result register is cleared at accept, so OR-ing in the new chunk places it.
  assign w_sum_next = r_sum | (WIDTH'(w_chunk_sum) << w_shamt);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(sat_min_neg(WIDTH));

  logic r_sat;

  // Overflow with carry-out set can only come from two negatives: clamp low.
  always_comb begin
    w_result = w_sum_next;
    if (r_sat && w_ovf) begin
      w_result = w_cout ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_sat <= sat;
    end
  end
`else
  assign w_result = w_sum_next;
`endif

  // Controller, operand shifters, result register and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_sum       <= w_result;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
            r_zero      <= (w_result == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_sum <= w_sum_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: three instances (CHUNK = 4, 16, 1) at WIDTH = 16,
// scoreboard queue filled at issue, drained by per-instance monitors.
module tb_addsub_multicycle;

  localparam int unsigned W  = 16;
  localparam int          NI = 3;

  function automatic int unsigned ch_of(input int g);
    case (g)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int n_of(input int g);
    return int'(W / ch_of(g));
  endfunction

  typedef struct packed {
    logic [7:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [W-1:0] a_s       [NI];
  logic [W-1:0] b_s       [NI];
  logic         cin_s     [NI];
  logic         sub_s     [NI];
`ifdef ADDSUB_SAT_EN
  logic         sat_s     [NI];
`endif
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [W-1:0] sum_s     [NI];
  logic         cout_s    [NI];
  logic         ovf_s     [NI];
  logic         zero_s    [NI];

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int g, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic su, input logic st);
    exp_t e;
    int   sa, sb, r;
    int   u;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    e.id = 8'(g);
    if (su) begin
      r      = sa - sb;
      e.sum  = av - bv;
      e.cout = (av >= bv);
    end else begin
      r      = sa + sb + int'(ci);
      u      = int'(av) + int'(bv) + int'(ci);
      e.sum  = W'(u);
      e.cout = (u >= 65536);
    end
    e.ovf = (r > 32767) || (r < -32768);
    if (st && e.ovf) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic score(input int g);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_result: inst %0d got sum 0x%0h, expected no result", g, sum_s[g]);
    end else begin
      e = exp_q.pop_front();
      chk("result_inst", 32'(g), 32'(e.id));
      chk("sum",  32'(sum_s[g]),  32'(e.sum));
      chk("cout", 32'(cout_s[g]), 32'(e.cout));
      chk("ovf",  32'(ovf_s[g]),  32'(e.ovf));
      chk("zero", 32'(zero_s[g]), 32'(e.zero));
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    addsub_multicycle #(.WIDTH(W), .CHUNK(ch_of(g))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a_s[g]),
      .b        (b_s[g]),
      .cin      (cin_s[g]),
      .sub      (sub_s[g]),
`ifdef ADDSUB_SAT_EN
      .sat      (sat_s[g]),
`endif
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .sum      (sum_s[g]),
      .cout     (cout_s[g]),
      .ovf      (ovf_s[g]),
      .zero     (zero_s[g])
    );

    // A handshake completes at the next rising edge whenever both are high here.
    always @(negedge clk) begin
      if (!rst && out_valid[g] && out_ready[g]) score(g);
    end
  end

  task automatic wait_ready(input int g);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_ready_wait", 32'(ok), 32'd1);
  endtask

  // Issue one operation, push its expected result, and check latency.
  task automatic send(input int g, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic su, input logic st);
    int   lat;
    logic st_eff;
`ifdef ADDSUB_SAT_EN
    st_eff = st;
`else
    st_eff = 1'b0;
`endif
    wait_ready(g);
    a_s[g]   = av;
    b_s[g]   = bv;
    cin_s[g] = ci;
    sub_s[g] = su;
`ifdef ADDSUB_SAT_EN
    sat_s[g] = st_eff;
`endif
    in_valid[g] = 1'b1;
    exp_q.push_back(model(g, av, bv, ci, su, st_eff));
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    a_s[g] = W'($urandom);
    b_s[g] = W'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid[g]) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(n_of(g)));
  endtask

  task automatic reset_mid(input int g);
    int seen;
    send(g, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    wait_ready(g);
    a_s[g] = 16'h1234; b_s[g] = 16'h1111; cin_s[g] = 1'b0; sub_s[g] = 1'b0;
    in_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    if (n_of(g) > 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
    chk("rst_sum",       32'(sum_s[g]),     32'd0);
    chk("rst_cout",      32'(cout_s[g]),    32'd0);
    chk("rst_zero",      32'(zero_s[g]),    32'd0);
    chk("rst_in_ready",  32'(in_ready[g]),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < n_of(g) + 3; i++) begin
      @(negedge clk);
      if (out_valid[g]) seen++;
    end
    chk("rst_no_result",      32'(seen),        32'd0);
    chk("rst_in_ready_after", 32'(in_ready[g]), 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = 1'b0; out_ready[g] = 1'b1;
      a_s[g] = '0; b_s[g] = '0; cin_s[g] = 1'b0; sub_s[g] = 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_s[g] = 1'b0;
`endif
    end
    #1 rst = 1'b1;
    #2;
    for (int g = 0; g < NI; g++) begin
      chk("reset_in_ready",  32'(in_ready[g]),  32'd1);
      chk("reset_out_valid", 32'(out_valid[g]), 32'd0);
      chk("reset_sum",       32'(sum_s[g]),     32'd0);
      chk("reset_flags",     32'({cout_s[g], ovf_s[g], zero_s[g]}), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases on the CHUNK=4 instance.
    send(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    send(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    send(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(0, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0);
    send(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0);
    send(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held, new operands ignored until handshake.
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    e = model(0, 16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    send(0, 16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    a_s[0] = 16'h1111; b_s[0] = 16'h2222; sub_s[0] = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_in_ready",  32'(in_ready[0]),  32'd0);
      chk("bp_sum",       32'(sum_s[0]),     32'(e.sum));
      chk("bp_flags",     32'({cout_s[0], ovf_s[0], zero_s[0]}), 32'({e.cout, e.ovf, e.zero}));
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_release_in_ready",  32'(in_ready[0]),  32'd1);

    // Mid-operation reset on each chunk configuration.
    for (int g = 0; g < NI; g++) reset_mid(g);

    // Randomized traffic on each configuration.
    for (int g = 0; g < NI; g++) begin
      for (int k = 0; k < 25; k++) begin
        send(g, pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
